wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameters: WORD_WIDTH, 32, data word width; REG_NUM_LOG, 5, register-address width.
REQ-002 SHALL have one clock and synchronous active-high reset, ports listed first: clk input 1 (all state updates on rising edge); rst input 1 (synchronous, active-high).
REQ-003 SHALL have port memValid input 1: MEM stage presents an instruction this cycle.
REQ-004 SHALL have port memRegWrite input 1: the instruction writes a register.
REQ-005 SHALL have port memWriteAddr input REG_NUM_LOG: destination register.
REQ-006 SHALL have port memAluResult input WORD_WIDTH: ALU result, or effective address for loads.
REQ-007 SHALL have port memLoadType input 3: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW; 6 and 7 are treated as 0.
REQ-008 SHALL have port memReadData input WORD_WIDTH: aligned memory word for loads.
REQ-009 SHALL have port hold input 1: freeze stage contents.
REQ-010 SHALL have port flush input 1: discard the incoming instruction.
REQ-011 SHALL have ports writeEnable output 1, writeAddr output REG_NUM_LOG and writeValue output WORD_WIDTH: register-file write port.
REQ-012 SHALL have port misaligned output 1: one-cycle pulse on a misaligned load.
REQ-013 SHALL have port retireCount output 32: count of retired instructions.

Function
REQ-014 SHALL hold a stage register (valid, regWrite, addr, aluResult, loadType, readData) plus a 1-bit fresh flag.
REQ-015 At each rising edge with hold=0: the stage register SHALL load the mem* inputs, with valid = memValid & ~flush; fresh SHALL be set to 1.
REQ-016 At each rising edge with hold=1: the stage register SHALL keep its contents and fresh SHALL clear to 0.
REQ-017 Priority SHALL be rst > hold > flush; flush during hold SHALL be ignored.
REQ-018 Latency SHALL be one cycle: inputs sampled at edge n drive the outputs from edge n until edge n+1, stable across the intervening falling edge where the register file samples.
REQ-019 The address byte offset off SHALL be aluResult[1:0]; byte lanes are little-endian, so off=0 selects bits 7:0 and off=3 selects bits 31:24.
REQ-020 LB/LBU SHALL take the byte at lane off, sign-extended for LB and zero-extended for LBU.
REQ-021 LH/LHU SHALL take the halfword at bits 15:0 when off[1]=0 and bits 31:16 when off[1]=1, sign-extended for LH and zero-extended for LHU.
REQ-022 LW SHALL take readData unchanged; loadType 0 SHALL take aluResult.
REQ-023 A misaligned load SHALL be LH/LHU with off[0]=1, or LW with off != 0; LB/LBU are never misaligned.
REQ-024 writeValue SHALL be the selected value combinationally from the stage register, and SHALL be 0 when the entry is not valid.
REQ-025 writeAddr SHALL equal the stored address.
REQ-026 writeEnable SHALL equal valid & fresh & regWrite & ~misaligned & (addr != 0).
REQ-027 misaligned output SHALL equal valid & fresh & (misaligned condition), asserting for exactly one cycle per instruction even when hold lasts many cycles.
REQ-028 retireCount SHALL increment by 1 at the edge ending each cycle in which valid & fresh & ~misaligned; this includes regWrite=0 and addr=0 instructions.
REQ-029 retireCount SHALL wrap from 0xFFFFFFFF to 0 with no flag.
REQ-030 No write SHALL be issued twice for one instruction.

Reset
REQ-031 On rst at a rising edge: valid=0, fresh=0, and all stored fields=0.
REQ-032 After reset, every output SHALL read 0, including retireCount.
REQ-033 rst mid-hold SHALL discard the held instruction, which SHALL never be written or counted.

Verification
REQ-034 ALU write: memValid=1, regWrite=1, addr=5, loadType=0, aluResult=0x12345678 -> next cycle writeEnable=1, writeAddr=5, writeValue=0x12345678; retireCount then 1.
REQ-035 Loads on readData=0x80FF7F01: LB off=3 -> 0xFFFFFF80; LBU off=3 -> 0x00000080; LH off=2 -> 0xFFFF80FF; LHU off=0 -> 0x00007F01; LW off=0 -> 0x80FF7F01.
REQ-036 Misalignment: LW with aluResult=0x1002, addr=7 -> writeEnable=0, misaligned=1 for one cycle, retireCount unchanged.
REQ-037 Hold: load an instruction to addr=3, then hold=1 for 4 cycles -> writeEnable=1 only in the first cycle, outputs stable, retireCount +1 total.
REQ-038 Flush and r0: flush=1 with valid input -> writeEnable=0 and no count; addr=0 with regWrite=1 -> writeEnable=0 and retireCount +1.
REQ-039 Wrap and reset: preload retireCount=0xFFFFFFFF by forcing, retire one instruction -> retireCount=0; assert rst mid-hold -> all outputs 0 next cycle.

Source files
------------

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage: write-back pipeline stage.
//
// Captures the instruction leaving the MEM stage, formats load data
// (byte/halfword extraction with sign/zero extension), detects misaligned
// loads, drives the register-file write port and counts retired
// instructions.
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   memValid        - MEM stage presents an instruction this cycle
//   memRegWrite     - instruction writes a register
//   memWriteAddr    - destination register
//   memAluResult    - ALU result, or effective address for loads
//   memLoadType     - 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW (6/7 = none)
//   memReadData     - aligned memory word for loads
//   hold            - freeze stage contents
//   flush           - discard the incoming instruction
//   writeEnable     - register-file write strobe
//   writeAddr       - register-file write address
//   writeValue      - register-file write data
//   misaligned      - one-cycle pulse on a misaligned load
//   retireCount     - count of retired instructions (wraps silently)
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int WORD_WIDTH  = 32,
  parameter int REG_NUM_LOG = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   memValid,
  input  logic                   memRegWrite,
  input  logic [REG_NUM_LOG-1:0] memWriteAddr,
  input  logic [WORD_WIDTH-1:0]  memAluResult,
  input  logic [2:0]             memLoadType,
  input  logic [WORD_WIDTH-1:0]  memReadData,
  input  logic                   hold,
  input  logic                   flush,
  output logic                   writeEnable,
  output logic [REG_NUM_LOG-1:0] writeAddr,
  output logic [WORD_WIDTH-1:0]  writeValue,
  output logic                   misaligned,
  output logic [31:0]            retireCount
);

  localparam logic [2:0] LT_NONE = 3'd0;
  localparam logic [2:0] LT_LB   = 3'd1;
  localparam logic [2:0] LT_LBU  = 3'd2;
  localparam logic [2:0] LT_LH   = 3'd3;
  localparam logic [2:0] LT_LHU  = 3'd4;
  localparam logic [2:0] LT_LW   = 3'd5;

  // Byte at little-endian lane 'off' of a word.
  function automatic logic [7:0] lane_byte(input logic [WORD_WIDTH-1:0] w,
                                           input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Load formatting: extract and extend the addressed byte/halfword.
  function automatic logic [WORD_WIDTH-1:0] load_select(
      input logic [2:0]            lt,
      input logic [WORD_WIDTH-1:0] alu,
      input logic [WORD_WIDTH-1:0] rd);
    logic [7:0]            b;
    logic [15:0]           h;
    logic [WORD_WIDTH-1:0] r;
    b = lane_byte(rd, alu[1:0]);
    h = alu[1] ? rd[31:16] : rd[15:0];
    case (lt)
      LT_LB:   r = {{(WORD_WIDTH-8){b[7]}}, b};
      LT_LBU:  r = {{(WORD_WIDTH-8){1'b0}}, b};
      LT_LH:   r = {{(WORD_WIDTH-16){h[15]}}, h};
      LT_LHU:  r = {{(WORD_WIDTH-16){1'b0}}, h};
      LT_LW:   r = rd;
      LT_NONE: r = alu;
      default: r = alu;   // 6 and 7 behave as "no load"
    endcase
    return r;
  endfunction

  // Alignment rule: halfwords need an even address, words a multiple of 4.
  function automatic logic is_misaligned(input logic [2:0] lt,
                                         input logic [1:0] off);
    logic m;
    case (lt)
      LT_LH, LT_LHU: m = off[0];
      LT_LW:         m = (off != 2'd0);
      default:       m = 1'b0;
    endcase
    return m;
  endfunction

  logic                   valid_q,       valid_d;
  logic                   reg_write_q,   reg_write_d;
  logic [REG_NUM_LOG-1:0] addr_q,        addr_d;
  logic [WORD_WIDTH-1:0]  alu_result_q,  alu_result_d;
  logic [2:0]             load_type_q,   load_type_d;
  logic [WORD_WIDTH-1:0]  read_data_q,   read_data_d;
  logic                   fresh_q,       fresh_d;
  logic [31:0]            retire_count_q, retire_count_d;

  logic                   mis_cond_s;
  logic                   live_s;
  logic                   retire_s;
  logic [WORD_WIDTH-1:0]  sel_value_s;

  // Output decode from the stage register.
  always_comb begin
    mis_cond_s  = is_misaligned(load_type_q, alu_result_q[1:0]);
    sel_value_s = load_select(load_type_q, alu_result_q, read_data_q);
    // 'fresh' limits side effects to the first cycle an entry is present,
    // so a held instruction is never written or counted twice.
    live_s      = valid_q & fresh_q;
    retire_s    = live_s & ~mis_cond_s;
  end

  // Next-state: hold freezes the entry, otherwise capture MEM outputs.
  always_comb begin
    valid_d        = valid_q;
    reg_write_d    = reg_write_q;
    addr_d         = addr_q;
    alu_result_d   = alu_result_q;
    load_type_d    = load_type_q;
    read_data_d    = read_data_q;
    fresh_d        = fresh_q;
    retire_count_d = retire_s ? (retire_count_q + 32'd1) : retire_count_q;
    if (hold) begin
      fresh_d = 1'b0;
    end else begin
      valid_d      = memValid & ~flush;
      reg_write_d  = memRegWrite;
      addr_d       = memWriteAddr;
      alu_result_d = memAluResult;
      load_type_d  = memLoadType;
      read_data_d  = memReadData;
      fresh_d      = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= 1'b0;
      reg_write_q    <= 1'b0;
      addr_q         <= '0;
      alu_result_q   <= '0;
      load_type_q    <= 3'd0;
      read_data_q    <= '0;
      fresh_q        <= 1'b0;
      retire_count_q <= 32'd0;
    end else begin
      valid_q        <= valid_d;
      reg_write_q    <= reg_write_d;
      addr_q         <= addr_d;
      alu_result_q   <= alu_result_d;
      load_type_q    <= load_type_d;
      read_data_q    <= read_data_d;
      fresh_q        <= fresh_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign writeValue  = valid_q ? sel_value_s : '0;
  assign writeAddr   = addr_q;
  assign writeEnable = live_s & reg_write_q & ~mis_cond_s & (addr_q != '0);
  assign misaligned  = live_s & mis_cond_s;
  assign retireCount = retire_count_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        memValid;
  logic        memRegWrite;
  logic [4:0]  memWriteAddr;
  logic [31:0] memAluResult;
  logic [2:0]  memLoadType;
  logic [31:0] memReadData;
  logic        hold;
  logic        flush;
  logic        writeEnable;
  logic [4:0]  writeAddr;
  logic [31:0] writeValue;
  logic        misaligned;
  logic [31:0] retireCount;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] val;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [31:0] RD = 32'h80FF7F01;

  wb_stage #(.WORD_WIDTH(32), .REG_NUM_LOG(5)) dut (
    .clk(clk), .rst(rst), .memValid(memValid), .memRegWrite(memRegWrite),
    .memWriteAddr(memWriteAddr), .memAluResult(memAluResult),
    .memLoadType(memLoadType), .memReadData(memReadData), .hold(hold),
    .flush(flush), .writeEnable(writeEnable), .writeAddr(writeAddr),
    .writeValue(writeValue), .misaligned(misaligned), .retireCount(retireCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=0x%08h required=0x%08h", nm, fld, act, req);
    end
  endtask

  // Monitor: the DUT presents its write-port outputs every cycle; compare
  // them against the expectation queued for that cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "we",   {31'd0, writeEnable}, {31'd0, e.we});
        chk(e.name, "addr", {27'd0, writeAddr},   {27'd0, e.addr});
        chk(e.name, "val",  writeValue,           e.val);
        chk(e.name, "mis",  {31'd0, misaligned},  {31'd0, e.mis});
        chk(e.name, "cnt",  retireCount,          e.cnt);
      end
    end
  end

  // One clock of stimulus: drive inputs, take the edge, queue the outputs
  // expected after that edge. Optionally preload the retire counter.
  task automatic step(input string nm, input logic r, input logic v,
                      input logic rw, input logic [4:0] a,
                      input logic [31:0] alu, input logic [2:0] lt,
                      input logic h, input logic f,
                      input logic e_we, input logic [4:0] e_addr,
                      input logic [31:0] e_val, input logic e_mis,
                      input logic [31:0] e_cnt, input bit preload = 1'b0);
    exp_t e;
    rst = r; memValid = v; memRegWrite = rw; memWriteAddr = a;
    memAluResult = alu; memLoadType = lt; memReadData = RD;
    hold = h; flush = f;
    @(posedge clk);
    e.name = nm; e.we = e_we; e.addr = e_addr; e.val = e_val;
    e.mis = e_mis; e.cnt = e_cnt;
    exp_q.push_back(e);
    #1;
    if (preload) begin
      force dut.retire_count_q = 32'hFFFFFFFF;
      #1;
      release dut.retire_count_q;
    end
  endtask

  initial begin
    //    name       rst v rw addr  alu           lt h f | we addr val           mis cnt
    step("reset",    1, 1, 1, 5'd9, 32'h1111,     3'd5,0,0,  0, 5'd0, 32'h0,        0, 32'd0);
    step("alu5",     0, 1, 1, 5'd5, 32'h12345678, 3'd0,0,0,  1, 5'd5, 32'h12345678, 0, 32'd0);
    step("lb3",      0, 1, 1, 5'd1, 32'h3,        3'd1,0,0,  1, 5'd1, 32'hFFFFFF80, 0, 32'd1);
    step("lbu3",     0, 1, 1, 5'd2, 32'h3,        3'd2,0,0,  1, 5'd2, 32'h00000080, 0, 32'd2);
    step("lh2",      0, 1, 1, 5'd3, 32'h2,        3'd3,0,0,  1, 5'd3, 32'hFFFF80FF, 0, 32'd3);
    step("lhu0",     0, 1, 1, 5'd4, 32'h0,        3'd4,0,0,  1, 5'd4, 32'h00007F01, 0, 32'd4);
    step("lw0",      0, 1, 1, 5'd6, 32'h0,        3'd5,0,0,  1, 5'd6, 32'h80FF7F01, 0, 32'd5);
    step("lw_mis",   0, 1, 1, 5'd7, 32'h1002,     3'd5,0,0,  0, 5'd7, 32'h80FF7F01, 1, 32'd6);
    step("idle1",    0, 0, 0, 5'd0, 32'h0,        3'd0,0,0,  0, 5'd0, 32'h0,        0, 32'd6);
    step("hold_ld",  0, 1, 1, 5'd3, 32'hAA,       3'd0,0,0,  1, 5'd3, 32'hAA,       0, 32'd6);
    for (int i = 0; i < 4; i++)
      step("hold",   0, 1, 1, 5'd9, 32'h55,       3'd0,1,1,  0, 5'd3, 32'hAA,       0, 32'd7);
    step("flush",    0, 1, 1, 5'd8, 32'h77,       3'd0,0,1,  0, 5'd8, 32'h0,        0, 32'd7);
    step("r0",       0, 1, 1, 5'd0, 32'h99,       3'd0,0,0,  0, 5'd0, 32'h99,       0, 32'd7);
    step("idle2",    0, 0, 0, 5'd0, 32'h0,        3'd0,0,0,  0, 5'd0, 32'h0,        0, 32'd8);
    step("lh_mis",   0, 1, 1, 5'd2, 32'h1,        3'd3,0,0,  0, 5'd2, 32'h00007F01, 1, 32'd8);
    step("lb1",      0, 1, 1, 5'd9, 32'h1,        3'd1,0,0,  1, 5'd9, 32'h0000007F, 0, 32'd8);
    step("lt6",      0, 1, 1, 5'd12,32'h33,       3'd6,0,0,  1, 5'd12,32'h33,       0, 32'd9);
    step("pre_wrap", 0, 1, 1, 5'd10,32'h1,        3'd0,0,0,  1, 5'd10,32'h1,        0, 32'hFFFFFFFF, 1'b1);
    step("wrap",     0, 0, 0, 5'd0, 32'h0,        3'd0,0,0,  0, 5'd0, 32'h0,        0, 32'd0);
    step("ld11",     0, 1, 1, 5'd11,32'h22,       3'd0,0,0,  1, 5'd11,32'h22,       0, 32'd0);
    step("hold11",   0, 1, 1, 5'd4, 32'h44,       3'd0,1,0,  0, 5'd11,32'h22,       0, 32'd1);
    step("rst_hold", 1, 1, 1, 5'd4, 32'h44,       3'd0,1,0,  0, 5'd0, 32'h0,        0, 32'd0);
    step("post_rst", 0, 0, 0, 5'd0, 32'h0,        3'd0,1,0,  0, 5'd0, 32'h0,        0, 32'd0);
    @(negedge clk);
    #1;
    chk("drain", "pending", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
